// File: rtl/stack_access_ctrl.sv
// Stack controller: push/pop through a single req/ack memory port, SP grows downward by words.
// Optional build macro STACK_SP_LOAD_EN adds a direct SP load port (sp_load / sp_load_val).
module stack_access_ctrl #(
    parameter int                 DATA_W   = 32,
    parameter logic [DATA_W-1:0]  SP_RESET = DATA_W'(32'h0000_03C0),
    parameter logic [DATA_W-1:0]  SP_LIMIT = DATA_W'(32'h0000_0300)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              push_req,
    input  logic              pop_req,
    input  logic [DATA_W-1:0] push_data,
`ifdef STACK_SP_LOAD_EN
    input  logic              sp_load,
    input  logic [DATA_W-1:0] sp_load_val,
`endif
    output logic              ready,
    output logic              pop_valid,
    output logic [DATA_W-1:0] pop_data,
    output logic [DATA_W-1:0] sp_out,
    output logic              full,
    output logic              empty,
    output logic              overflow_err,
    output logic              underflow_err,
    output logic [DATA_W-1:0] mem_addr,
    output logic              mem_we,
    output logic              mem_re,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    typedef enum logic [1:0] {IDLE, PUSH_WR, POP_RD, DONE} state_t;

    typedef struct packed {
        logic              we;
        logic              re;
        logic [DATA_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } mem_req_t;

    // Word-align the reset value so sp_out[1:0] stays zero for any parameterisation.
    localparam logic [DATA_W-1:0] SP_INIT = {SP_RESET[DATA_W-1:2], 2'b00};
    localparam logic [DATA_W-1:0] WORD    = DATA_W'(4);

    state_t            state;
    mem_req_t          mreq;
    logic [DATA_W-1:0] sp;
    logic [DATA_W-1:0] sp_dec;
    logic              load_req;
    logic [DATA_W-1:0] load_val;

`ifdef STACK_SP_LOAD_EN
    assign load_req = sp_load;
    assign load_val = {sp_load_val[DATA_W-1:2], 2'b00};
`else
    assign load_req = 1'b0;
    assign load_val = '0;
`endif

    assign sp_dec    = sp - WORD;
    assign sp_out    = sp;
    assign full      = (sp == SP_LIMIT);
    assign empty     = (sp == SP_RESET);
    assign mem_we    = mreq.we;
    assign mem_re    = mreq.re;
    assign mem_addr  = mreq.addr;
    assign mem_wdata = mreq.wdata;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            ready         <= 1'b1;
            sp            <= SP_INIT;
            mreq          <= '0;
            pop_data      <= '0;
            pop_valid     <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            pop_valid     <= 1'b0;
            overflow_err  <= 1'b0;
            underflow_err <= 1'b0;
            case (state)
                IDLE: begin
                    // Load beats push beats pop; rejected requests are consumed in place.
                    if (load_req) begin
                        sp <= load_val;
                    end else if (push_req) begin
                        if (full) begin
                            overflow_err <= 1'b1;
                        end else begin
                            sp         <= sp_dec;
                            mreq.addr  <= sp_dec;
                            mreq.wdata <= push_data;
                            mreq.we    <= 1'b1;
                            ready      <= 1'b0;
                            state      <= PUSH_WR;
                        end
                    end else if (pop_req) begin
                        if (empty) begin
                            underflow_err <= 1'b1;
                        end else begin
                            mreq.addr <= sp;
                            mreq.re   <= 1'b1;
                            ready     <= 1'b0;
                            state     <= POP_RD;
                        end
                    end
                end
                PUSH_WR: begin
                    if (mem_ack) begin
                        mreq.we <= 1'b0;
                        state   <= DONE;
                    end
                end
                POP_RD: begin
                    if (mem_ack) begin
                        mreq.re   <= 1'b0;
                        pop_data  <= mem_rdata;
                        sp        <= sp + WORD;
                        pop_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    ready <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    mreq  <= '0;
                    ready <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_access_ctrl.sv
// Randomised bench for stack_access_ctrl against a queue-based stack model and a word memory responder.
module tb_stack_access_ctrl;

    localparam logic [31:0] SPR  = 32'h0000_03C0;
    localparam logic [31:0] SPL  = 32'h0000_0300;
    localparam int          MAXD = (SPR - SPL) / 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        push_req = 1'b0;
    logic        pop_req = 1'b0;
    logic [31:0] push_data = '0;
    logic        ready, pop_valid, full, empty, overflow_err, underflow_err;
    logic [31:0] pop_data, sp_out, mem_addr, mem_wdata;
    logic        mem_we, mem_re;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    stack_access_ctrl dut (
        .clk(clk), .reset(reset), .push_req(push_req), .pop_req(pop_req), .push_data(push_data),
`ifdef STACK_SP_LOAD_EN
        .sp_load(1'b0), .sp_load_val(32'h0),
`endif
        .ready(ready), .pop_valid(pop_valid), .pop_data(pop_data), .sp_out(sp_out),
        .full(full), .empty(empty), .overflow_err(overflow_err), .underflow_err(underflow_err),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_re(mem_re), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int ack_delay = 1;
    int pv_cnt = 0, ovf_cnt = 0, unf_cnt = 0, we_cyc = 0, re_cyc = 0, both_cnt = 0;
    logic [31:0] wr_addr = '0, wr_data = '0, rd_addr = '0;
    logic [31:0] tbmem [256];

    // Reference stack model
    logic [31:0] stk [$];
    logic [31:0] last_pop = '0;

    // Memory responder and event monitor; acks after ack_delay access cycles, with stray acks in DONE.
    initial begin : resp
        int cnt;
        cnt = 0;
        mem_ack = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clk);
            if (pop_valid) pv_cnt++;
            if (overflow_err) ovf_cnt++;
            if (underflow_err) unf_cnt++;
            if (mem_we && mem_re) both_cnt++;
            if (mem_we) begin we_cyc++; wr_addr = mem_addr; wr_data = mem_wdata; end
            if (mem_re) begin re_cyc++; rd_addr = mem_addr; end
            if (mem_ack) begin
                cnt = 0;
                mem_rdata = $urandom;
                mem_ack = !ready && !mem_we && !mem_re && ($urandom_range(0, 1) == 1);
            end else if (mem_we || mem_re) begin
                cnt++;
                if (cnt >= ack_delay) begin
                    mem_ack = 1'b1;
                    if (mem_we) tbmem[mem_addr[9:2]] = mem_wdata;
                    else        mem_rdata = tbmem[mem_addr[9:2]];
                end
            end else begin
                cnt = 0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] sp_model();
        return SPR - 32'(4 * stk.size());
    endfunction

    task automatic do_reset();
        #2 reset = 1'b0;
        #1;
        chk("rst_sp", sp_out, SPR);
        chk("rst_we_re", {30'd0, mem_we, mem_re}, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wdata", mem_wdata, 32'd0);
        chk("rst_pop_data", pop_data, 32'd0);
        chk("rst_pulses", {29'd0, pop_valid, overflow_err, underflow_err}, 32'd0);
        chk("rst_flags", {29'd0, ready, full, empty}, 32'b101);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stk.delete();
        last_pop = '0;
        #1;
    endtask

    // One request from IDLE; push wins when both are raised, leaving pop_req pending.
    task automatic do_op(input bit pv, input bit po, input logic [31:0] d, input int dly);
        int lat, p0, o0, u0, w0, r0;
        logic [31:0] sp0;
        lat = 0;
        while (!ready && lat < 50) begin @(negedge clk); lat++; end
        #1;
        chk("ready_before_op", {31'd0, ready}, 32'd1);
        ack_delay = dly;
        push_data = d;
        p0 = pv_cnt; o0 = ovf_cnt; u0 = unf_cnt; w0 = we_cyc; r0 = re_cyc;
        sp0 = sp_model();
        push_req = pv;
        pop_req = po;
        @(posedge clk);
        #1;
        if (pv) push_req = 1'b0;
        else    pop_req = 1'b0;
        lat = 0;
        do begin @(negedge clk); lat++; end while (!ready && lat < 100);
        #1;
        if (pv && stk.size() == MAXD) begin
            chk("ovf_lat", lat, 1);
            chk("ovf_pulse", ovf_cnt - o0, 1);
            chk("ovf_no_we", we_cyc - w0, 0);
        end else if (pv) begin
            chk("push_lat", lat, dly + 2);
            chk("push_we_cycles", we_cyc - w0, dly);
            chk("push_addr", wr_addr, sp0 - 32'd4);
            chk("push_wdata", wr_data, d);
            chk("push_no_err", ovf_cnt - o0, 0);
            stk.push_back(d);
        end else if (stk.size() == 0) begin
            chk("unf_lat", lat, 1);
            chk("unf_pulse", unf_cnt - u0, 1);
            chk("unf_no_re", re_cyc - r0, 0);
        end else begin
            chk("pop_lat", lat, dly + 2);
            chk("pop_re_cycles", re_cyc - r0, dly);
            chk("pop_addr", rd_addr, sp0);
            chk("pop_valid_once", pv_cnt - p0, 1);
            last_pop = stk.pop_back();
        end
        if (!(pv == 0 && stk.size() > 0 && 0)) begin end
        if (!pv) chk("no_stray_ovf", ovf_cnt - o0, 0);
        if (pv)  chk("no_stray_pv", pv_cnt - p0, 0);
        chk("pop_data", pop_data, last_pop);
        chk("sp_out", sp_out, sp_model());
        chk("full", {31'd0, full}, {31'd0, stk.size() == MAXD});
        chk("empty", {31'd0, empty}, {31'd0, stk.size() == 0});
    endtask

    initial begin : watchdog
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin : main
        int pv0;
        int r;
        repeat (2) @(negedge clk);
        do_reset();

        // Single push, then delayed-ack pop of the same word
        do_op(1'b1, 1'b0, 32'hDEAD_BEEF, 1);
        chk("push_sp_3bc", sp_out, 32'h0000_03BC);
        do_op(1'b0, 1'b1, 32'h0, 4);
        chk("pop_deadbeef", pop_data, 32'hDEAD_BEEF);
        chk("pop_sp_3c0", sp_out, 32'h0000_03C0);

        // Pop from empty
        do_op(1'b0, 1'b1, 32'h0, 1);

        // Simultaneous push and pop: push first, pop returns it
        do_op(1'b1, 1'b1, 32'hA5A5_1234, 2);
        do_op(1'b0, 1'b1, 32'h0, 3);
        chk("both_pop_data", pop_data, 32'hA5A5_1234);
        chk("both_sp", sp_out, 32'h0000_03C0);

        // Fill to the limit, then one more push
        do_reset();
        for (int i = 0; i < MAXD; i++) do_op(1'b1, 1'b0, $urandom, $urandom_range(1, 3));
        chk("fill_sp_300", sp_out, 32'h0000_0300);
        chk("fill_full", {31'd0, full}, 32'd1);
        do_op(1'b1, 1'b0, 32'hBAD0_BAD0, 1);
        do_op(1'b0, 1'b1, 32'h0, 2);

        // Reset in the middle of a pop, before its ack
        do_reset();
        do_op(1'b1, 1'b0, 32'h1234_5678, 1);
        ack_delay = 1000;
        pv0 = pv_cnt;
        pop_req = 1'b1;
        @(posedge clk);
        #1 pop_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("midpop_re_high", {31'd0, mem_re}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("midpop_re_drop", {31'd0, mem_re}, 32'd0);
        chk("midpop_sp", sp_out, 32'h0000_03C0);
        chk("midpop_addr", mem_addr, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        stk.delete();
        last_pop = '0;
        repeat (3) @(negedge clk);
        #1;
        chk("midpop_no_pv", pv_cnt - pv0, 0);
        chk("midpop_ready", {31'd0, ready}, 32'd1);
        ack_delay = 1;

        // Random walk biased toward push so both boundaries get exercised
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 99);
            if (r < 55)      do_op(1'b1, 1'b0, $urandom, $urandom_range(1, 4));
            else if (r < 65) begin
                do_op(1'b1, 1'b1, $urandom, $urandom_range(1, 4));
                do_op(1'b0, 1'b1, 32'h0, $urandom_range(1, 4));
            end else         do_op(1'b0, 1'b1, 32'h0, $urandom_range(1, 4));
        end

        chk("we_re_exclusive", both_cnt, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
